spi_xfer_fsm: RTL and testbench
===============================

// Module: spi_xfer_fsm
// PURPOSE
//  SPI-slave transaction sequencer for the serial/parallel shift register.
//  It counts conditioned SCLK edges during a chip-select window and decodes a
//  frame of ADDR_BITS address bits plus 1 R/W bit (0 = write, 1 = read).
//  It drives the shift register edge and load controls, the address latch,
//  the data-memory write strobe and the MISO tristate enable.
// PARAMETERS
//  ADDR_BITS  7  address bits per frame; shift register width >= ADDR_BITS+1
//  DATA_BITS  8  data bits per frame; equals shift register width
//  CNT_W      4  bit-counter width; must hold max(ADDR_BITS+1, DATA_BITS)
// PORTS
//  clk          in   1  FPGA clock; all state changes on posedge
//  rst_n        in   1  asynchronous active-low reset
//  csN          in   1  conditioned chip select, active low
//  sclkPosEdge  in   1  one-clk pulse per SCLK rising edge (conditioned)
//  sclkNegEdge  in   1  one-clk pulse per SCLK falling edge (conditioned)
//  rwBit        in   1  shift register parallelDataOut[0] (R/W bit after address)
//  srEdge       out  1  to shift register peripheralClkEdge
//  srLoad       out  1  to shift register parallelLoad
//  addrWE       out  1  one-clk strobe: latch address from shift register
//  dmWE         out  1  one-clk strobe: write data memory
//  misoBufe     out  1  MISO output buffer enable
//  busy         out  1  high in every state except IDLE
// BEHAVIOUR
//  - rst_n low: state=IDLE, bitCnt=0, and all outputs 0 immediately (async).
//  - Outputs are Moore-decoded from the state, except srEdge, which gates
//    the edge pulses combinationally.
//  - States and transitions. A csN-high abort has the highest priority.
//    IDLE: csN low -> GET_ADDR with bitCnt=0.
//    GET_ADDR: srEdge=sclkPosEdge. bitCnt++ on each sclkPosEdge.
//      On the ADDR_BITS+1-th posedge -> DECODE with bitCnt=0.
//    DECODE (1 clk): addrWE=1. rwBit=1 -> READ_LOAD; rwBit=0 -> WRITE_GET.
//    READ_LOAD (1 clk): srLoad=1, srEdge=1 (forced), misoBufe=1 -> READ_SEND.
//    READ_SEND: misoBufe=1. srEdge=sclkNegEdge AND bitCnt!=0.
//      The negedge before the first data posedge does not shift, so the MSB
//      holds for the first sample.
//      bitCnt++ on each sclkPosEdge. On the DATA_BITS-th posedge -> DONE.
//    WRITE_GET: srEdge=sclkPosEdge. bitCnt++ on each sclkPosEdge.
//      On the DATA_BITS-th posedge -> WRITE_STORE.
//    WRITE_STORE (1 clk): dmWE=1 -> DONE.
//    DONE: all strobes 0; stays until csN high -> IDLE.
//  - Abort: csN high in any non-IDLE state -> IDLE on the next clk; bitCnt=0.
//    If csN goes high in the same clk as the final data posedge in WRITE_GET,
//    WRITE_STORE is not entered and dmWE never pulses.
//  - In IDLE or DONE, sclk pulses are ignored: srEdge=0 and bitCnt holds 0.
//  - srLoad is never high unless srEdge is high in the same clk.
//  - addrWE, dmWE and srLoad each pulse at most once per csN-low window.
//  - Timing: DECODE+READ_LOAD take 2 clk after the last address posedge.
//    The SCLK half-period must be >= 4 clk; faster SCLK is unsupported.
//  - bitCnt saturates at no value; the compare is exact. Widths follow CNT_W.
// TESTING
//  1 Write, addr 0x2A, data 0xC3: 8 posedges then 8 posedges.
//    -> addrWE 1 clk after the 8th posedge; dmWE exactly 1 clk, 1 clk after
//    the 16th posedge; srEdge on all 16 posedges.
//  2 Read, addr 0x55 (rwBit=1). -> addrWE, then srLoad=srEdge=1 for 1 clk;
//    misoBufe high from READ_LOAD until csN high; srEdge on 7 negedges only.
//  3 Abort: csN high after the 4th data posedge of a write. -> IDLE next clk;
//    dmWE never asserts; busy=0.
//  4 Reset mid-read: rst_n low during READ_SEND. -> all outputs 0 with no
//    clk edge; after release, the next csN-low frame decodes normally.
//  5 Back-to-back: write then read with csN high for 2 clk between.
//    -> each frame produces its own single addrWE; no strobe leaks across.
//  6 Extra posedges in DONE, and csN high on the final write posedge.
//    -> srEdge stays 0 in DONE; no dmWE for the truncated frame.

Source files
------------

// File: rtl/spi_xfer_fsm.sv
// spi_xfer_fsm: SPI-slave frame sequencer driving shift register, address latch, memory write and MISO enable
module spi_xfer_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic csN,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic rwBit,
    output logic srEdge,
    output logic srLoad,
    output logic addrWE,
    output logic dmWE,
    output logic misoBufe,
    output logic busy
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, DECODE, READ_LOAD, READ_SEND, WRITE_GET, WRITE_STORE, DONE
    } state_t;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;

    // State, bit counter and read-frame flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Next state: csN-high abort wins, otherwise walk the frame counting posedges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        if (state_q != IDLE && csN) begin
            state_d = IDLE;
            cnt_d   = '0;
            rd_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    rd_d  = 1'b0;
                    if (!csN) state_d = GET_ADDR;
                end
                GET_ADDR: if (sclkPosEdge) begin
                    cnt_d   = cnt_q == ADDR_LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == ADDR_LAST ? DECODE : GET_ADDR;
                end
                DECODE: begin
                    rd_d    = rwBit;
                    state_d = rwBit ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: state_d = READ_SEND;
                READ_SEND: if (sclkPosEdge) begin
                    cnt_d   = cnt_q == DATA_LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == DATA_LAST ? DONE : READ_SEND;
                end
                WRITE_GET: if (sclkPosEdge) begin
                    cnt_d   = cnt_q == DATA_LAST ? '0 : cnt_q + 1'b1;
                    state_d = cnt_q == DATA_LAST ? WRITE_STORE : WRITE_GET;
                end
                WRITE_STORE: state_d = DONE;
                DONE: cnt_d = '0;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from state; srEdge additionally gates the SCLK edge pulses
    always_comb begin
        srEdge   = (state_q == GET_ADDR || state_q == WRITE_GET) ? sclkPosEdge :
                   state_q == READ_LOAD ? 1'b1 :
                   state_q == READ_SEND ? (sclkNegEdge && cnt_q != '0) : 1'b0;
        srLoad   = state_q == READ_LOAD;
        addrWE   = state_q == DECODE;
        dmWE     = state_q == WRITE_STORE;
        misoBufe = state_q == READ_LOAD || state_q == READ_SEND || (state_q == DONE && rd_q);
        busy     = state_q != IDLE;
    end
endmodule

// File: tb/tb_spi_xfer_fsm.sv
// tb_spi_xfer_fsm: directed frame-level bench for the SPI transaction sequencer
module tb_spi_xfer_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic csN = 1'b1;
    logic sclkPosEdge = 1'b0;
    logic sclkNegEdge = 1'b0;
    logic rwBit = 1'b0;
    logic srEdge, srLoad, addrWE, dmWE, misoBufe, busy;
    int checks = 0;
    int errors = 0;
    int n_edge = 0, n_addr = 0, n_dm = 0, n_load = 0, n_bad = 0;

    spi_xfer_fsm dut (
        .clk(clk), .rst_n(rst_n), .csN(csN), .sclkPosEdge(sclkPosEdge),
        .sclkNegEdge(sclkNegEdge), .rwBit(rwBit), .srEdge(srEdge), .srLoad(srLoad),
        .addrWE(addrWE), .dmWE(dmWE), .misoBufe(misoBufe), .busy(busy)
    );

    always #5 clk = ~clk;

    // Per-cycle event counters, sampled mid-cycle
    always @(negedge clk) begin
        if (srEdge) n_edge++;
        if (addrWE) n_addr++;
        if (dmWE) n_dm++;
        if (srLoad) n_load++;
        if (srLoad && !srEdge) n_bad++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic pos();
        sclkPosEdge = 1'b1;
        clk1();
        sclkPosEdge = 1'b0;
    endtask

    task automatic neg();
        sclkNegEdge = 1'b1;
        clk1();
        sclkNegEdge = 1'b0;
    endtask

    task automatic gap();
        repeat (3) clk1();
    endtask

    task automatic clr();
        n_edge = 0;
        n_addr = 0;
        n_dm = 0;
        n_load = 0;
    endtask

    task automatic start(input logic rw);
        csN = 1'b0;
        rwBit = rw;
        clk1();
        check("busy_start", busy, 1);
    endtask

    task automatic addr_phase(input logic rw);
        clr();
        for (int i = 0; i < 8; i++) begin
            pos();
            if (i == 7) begin
                check("addrwe_after_8th", addrWE, 1);
                clk1();
                check("srload_readload", srLoad, rw);
                check("sredge_readload", srEdge, rw);
                check("misobufe_readload", misoBufe, rw);
                clk1();
                clk1();
            end else gap();
            neg();
            gap();
        end
        check("addrwe_count", n_addr, 1);
        check("addr_edge_count", n_edge, 8 + rw);
        check("load_count", n_load, rw);
    endtask

    task automatic data_phase(input logic rw);
        clr();
        for (int i = 0; i < 8; i++) begin
            pos();
            if (i == 7 && !rw) begin
                check("dmwe_after_last", dmWE, 1);
                clk1();
                check("dmwe_one_clk", dmWE, 0);
            end
            if (rw) check("misobufe_send", misoBufe, 1);
            gap();
            neg();
            gap();
        end
        check("busy_done", busy, 1);
        check("data_edge_count", n_edge, rw ? 7 : 8);
        check("dmwe_count", n_dm, rw ? 0 : 1);
    endtask

    task automatic finish_frame();
        csN = 1'b1;
        clk1();
        check("busy_after_cs", busy, 0);
        check("misobufe_after_cs", misoBufe, 0);
        clk1();
    endtask

    task automatic full_frame(input logic rw);
        start(rw);
        addr_phase(rw);
        data_phase(rw);
        finish_frame();
    endtask

    initial begin
        clk1();
        clk1();
        check("rst_busy", busy, 0);
        check("rst_strobes", {srEdge, srLoad, addrWE, dmWE, misoBufe}, 0);
        rst_n = 1'b1;
        clk1();
        check("idle_busy", busy, 0);

        // write, then extra SCLK activity while parked in DONE
        start(1'b0);
        addr_phase(1'b0);
        data_phase(1'b0);
        clr();
        repeat (2) begin
            pos();
            gap();
            neg();
            gap();
        end
        check("done_no_edge", n_edge, 0);
        check("done_busy", busy, 1);
        finish_frame();

        // read frame
        start(1'b1);
        addr_phase(1'b1);
        data_phase(1'b1);
        check("misobufe_in_done", misoBufe, 1);
        finish_frame();

        // abort after the 4th data posedge of a write
        start(1'b0);
        addr_phase(1'b0);
        clr();
        for (int i = 0; i < 4; i++) begin
            pos();
            gap();
            neg();
            gap();
        end
        csN = 1'b1;
        clk1();
        check("abort_busy", busy, 0);
        pos();
        check("abort_idle_edge", srEdge, 0);
        gap();
        check("abort_no_dmwe", n_dm, 0);

        // reset in the middle of READ_SEND
        start(1'b1);
        addr_phase(1'b1);
        for (int i = 0; i < 3; i++) begin
            pos();
            gap();
            neg();
            gap();
        end
        check("read_busy_pre_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_outs", {srEdge, srLoad, addrWE, dmWE, misoBufe}, 0);
        csN = 1'b1;
        clk1();
        clk1();
        rst_n = 1'b1;
        clk1();
        full_frame(1'b0);

        // back-to-back write then read, csN high 2 clk between
        full_frame(1'b0);
        full_frame(1'b1);

        // csN rises on the final write posedge
        start(1'b0);
        addr_phase(1'b0);
        clr();
        for (int i = 0; i < 7; i++) begin
            pos();
            gap();
            neg();
            gap();
        end
        sclkPosEdge = 1'b1;
        csN = 1'b1;
        clk1();
        sclkPosEdge = 1'b0;
        check("trunc_busy", busy, 0);
        check("trunc_dmwe", dmWE, 0);
        gap();
        check("trunc_no_dmwe", n_dm, 0);
        check("load_without_edge", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
